victory_seq: RTL
================

Name: victory_seq

Overview:
- Parametrised successor to the tug-of-war victory display.
- Drives an N-LED bar from the round result: centre marker while idle, then a blinking and held winner pattern at the end of each round.
- Keeps per-player round scores and declares a match winner at ROUNDS_TO_WIN.
- Sits between the game-core `over`/`winright` outputs and the LED pins; all timing advances on the shared slow enable `slowen256`.

Parameters:
- NLEDS, 7, LED bar width; must be odd and >= 3. Centre index C = NLEDS/2.
- BLINKS, 3, winner-pattern on/off blink pairs per round.
- HOLD_TICKS, 4, slow ticks the winner pattern is held solid after blinking; must be >= 1.
- ROUNDS_TO_WIN, 3, round wins that end the match; must be >= 1.
- SCORE_W, 2, score counter width; must satisfy 2^SCORE_W > ROUNDS_TO_WIN.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- slowen256  in  1  one-clk-wide slow tick enable
- over  in  1  round finished (level, sampled only on a tick)
- winright  in  1  1 = right player won the round; valid while `over` is high
- new_match  in  1  synchronous clear of scores, exits MATCH
- vict_leds  out  NLEDS  LED bar
- busy  out  1  high in BLINK, HOLD and MATCH
- score_l  out  SCORE_W  left player round wins
- score_r  out  SCORE_W  right player round wins
- match_over  out  1  high in MATCH

Behaviour:
- Clocking: one clock, `clk`; `rst` is asynchronous and active-high. All registers update on posedge clk; state advances only when `slowen256`=1, except `new_match`.
- Patterns:
  - CTR = bit C only.
  - RPAT = bits [C:0] set.
  - LPAT = bits [NLEDS-1:C] set.
  - WPAT = RPAT if latched winner is right, else LPAT.
- Reset: state IDLE, vict_leds=CTR, scores 0, busy=0, match_over=0, counters 0, winner latch 0.
- IDLE:
  - Outputs: vict_leds=CTR.
  - On tick & over: latch winner=winright; increment the winner's score (saturates at ROUNDS_TO_WIN); cnt=0; phase=on; go to BLINK.
  - `over` without a tick is ignored.
- BLINK:
  - Outputs: vict_leds = phase ? WPAT : 0.
  - Each tick: toggle phase, cnt++.
  - When cnt reaches 2*BLINKS-1 on a tick: cnt=0, go to HOLD.
  - BLINKS=0: go straight from IDLE to HOLD.
- HOLD:
  - Outputs: vict_leds=WPAT.
  - Each tick: cnt++.
  - When cnt reaches HOLD_TICKS-1 on a tick: if the winner's score == ROUNDS_TO_WIN go to MATCH, else go to IDLE.
- MATCH:
  - Outputs: vict_leds=WPAT, match_over=1.
  - Stays here until new_match or rst.
- new_match (any state, no tick needed): next cycle scores=0, cnt=0, state=IDLE. Has priority over tick-driven transitions in the same cycle.
- Other inputs: `over` and `winright` are ignored outside IDLE; a round ending during BLINK or HOLD is not counted.
- Simultaneous tick & over in the last HOLD tick: the HOLD exit happens; the new `over` is seen only on the next tick in IDLE.
- Illegal state encoding: next state IDLE, scores unchanged.
- Outputs are registered or decoded from registered state only; latency is one clk from the qualifying tick edge.
- Counter width: $clog2(max(2*BLINKS, HOLD_TICKS, NLEDS)+1).

Optional Feature:
- Macro: VICT_SWEEP_EN.
- Defined: in MATCH the bar shows a single lit LED.
  - Starts at C and moves one position toward the winner's edge (bit 0 for right, bit NLEDS-1 for left) per tick.
  - After reaching the edge it wraps to C on the next tick.
  - match_over is unchanged.
- Undefined: MATCH shows WPAT solid; the sweep position register is absent.

Decomposition:
- Package victory_pkg:
  - State encoding localparams: IDLE, BLINK, HOLD, MATCH.
  - Pattern-builder functions: ctr_pat, r_pat, l_pat, parameterised by NLEDS.
  - The counter-width function.
- Sub-module vict_tick_cnt:
  - Generic tick-qualified up-counter with sync clear and terminal-count compare input.
  - Used for the blink/hold count (and for the sweep position when VICT_SWEEP_EN is defined).

Test Plan (NLEDS=7, BLINKS=3, HOLD_TICKS=4, ROUNDS_TO_WIN=3):
1. Reset mid-BLINK → same cycle: vict_leds=0001000, scores 0/0, busy=0.
2. Right win: over=1, winright=1 on a tick → score_r=1; leds sequence per tick 0001111, 0000000 ×3 pairs; then 0001111 for 4 ticks; then 0001000, busy=0.
3. Left win: leds 1111000 blink ×3 then held; score_l=1, score_r=0.
4. over held high during BLINK/HOLD → no extra score increment; after IDLE is re-entered the next tick with over=1 starts a new round.
5. Three right wins → after the third HOLD, match_over=1, leds 0001111 static for ≥10 ticks. new_match pulse → next clk: IDLE, scores 0/0. With VICT_SWEEP_EN instead: 0001000, 0000100, 0000010, 0000001, 0001000 repeating.
6. over=1 without slowen256 for 50 clks → no change; new_match and tick in the same cycle in HOLD → IDLE, scores cleared.

Source files
------------

// File: rtl/victory_pkg.sv
`default_nettype none
// victory_pkg: state encoding, LED pattern builders and counter sizing shared by victory_seq.
package victory_pkg;

  localparam int MAX_LEDS = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLINK = 2'd1,
    HOLD  = 2'd2,
    MATCH = 2'd3
  } state_e;

  function automatic logic [MAX_LEDS-1:0] ctr_pat(input int nleds);
    logic [MAX_LEDS-1:0] p;
    p = '0;
    for (int i = 0; i < MAX_LEDS; i++) begin
      if (i == nleds / 2) p[i] = 1'b1;
    end
    return p;
  endfunction

  // Right winner lights the centre and everything toward bit 0.
  function automatic logic [MAX_LEDS-1:0] r_pat(input int nleds);
    logic [MAX_LEDS-1:0] p;
    p = '0;
    for (int i = 0; i < MAX_LEDS; i++) begin
      if (i <= nleds / 2) p[i] = 1'b1;
    end
    return p;
  endfunction

  function automatic logic [MAX_LEDS-1:0] l_pat(input int nleds);
    logic [MAX_LEDS-1:0] p;
    p = '0;
    for (int i = 0; i < MAX_LEDS; i++) begin
      if (i >= nleds / 2 && i < nleds) p[i] = 1'b1;
    end
    return p;
  endfunction

  function automatic int cnt_w(input int blinks, input int hold, input int nleds);
    int m;
    m = 2 * blinks;
    if (hold > m) m = hold;
    if (nleds > m) m = nleds;
    return $clog2(m + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/vict_tick_cnt.sv
`default_nettype none
// vict_tick_cnt: tick-qualified up-counter with synchronous clear and terminal-count compare.
module vict_tick_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  input  logic         clr_i,
  input  logic [W-1:0] tc_i,
  output logic [W-1:0] cnt_o,
  output logic         tc_hit_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign cnt_o    = cnt_q;
  assign tc_hit_o = (cnt_q == tc_i);

endmodule
`default_nettype wire

// File: rtl/victory_seq.sv
`default_nettype none
// victory_seq: round-result LED bar sequencer with per-player scores and match detection.
// Optional VICT_SWEEP_EN: single LED sweeps toward the winner's edge while in MATCH.
module victory_seq
  import victory_pkg::*;
#(
  parameter int NLEDS         = 7,
  parameter int BLINKS        = 3,
  parameter int HOLD_TICKS    = 4,
  parameter int ROUNDS_TO_WIN = 3,
  parameter int SCORE_W       = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               slowen256,
  input  logic               over,
  input  logic               winright,
  input  logic               new_match,
  output logic [NLEDS-1:0]   vict_leds,
  output logic               busy,
  output logic [SCORE_W-1:0] score_l,
  output logic [SCORE_W-1:0] score_r,
  output logic               match_over
);

  localparam int CW = cnt_w(BLINKS, HOLD_TICKS, NLEDS);
  localparam int C  = NLEDS / 2;

  localparam logic [MAX_LEDS-1:0] CTR_F  = ctr_pat(NLEDS);
  localparam logic [MAX_LEDS-1:0] RPAT_F = r_pat(NLEDS);
  localparam logic [MAX_LEDS-1:0] LPAT_F = l_pat(NLEDS);
  localparam logic [NLEDS-1:0]    CTR    = CTR_F[NLEDS-1:0];
  localparam logic [NLEDS-1:0]    RPAT   = RPAT_F[NLEDS-1:0];
  localparam logic [NLEDS-1:0]    LPAT   = LPAT_F[NLEDS-1:0];

  localparam int           BLINK_TC_I = (BLINKS > 0) ? 2 * BLINKS - 1 : 0;
  localparam logic [CW-1:0] BLINK_TC  = CW'(BLINK_TC_I);
  localparam logic [CW-1:0] HOLD_TC   = CW'(HOLD_TICKS - 1);
  localparam logic [SCORE_W-1:0] RTW  = SCORE_W'(ROUNDS_TO_WIN);
  localparam state_e ROUND_ENTRY      = (BLINKS > 0) ? BLINK : HOLD;

  state_e             state_q, state_d;
  logic               win_q, win_d;
  logic [SCORE_W-1:0] sl_q, sl_d;
  logic [SCORE_W-1:0] sr_q, sr_d;
  logic               busy_q, match_q;

  logic               cnt_en, cnt_clr, cnt_hit;
  logic [CW-1:0]      cnt_tc, cnt_val;
  logic [SCORE_W-1:0] win_score;
  logic [NLEDS-1:0]   wpat;
  logic               phase_on;

  vict_tick_cnt #(.W(CW)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .en_i     (cnt_en),
    .clr_i    (cnt_clr),
    .tc_i     (cnt_tc),
    .cnt_o    (cnt_val),
    .tc_hit_o (cnt_hit)
  );

  assign win_score = win_q ? sr_q : sl_q;
  assign wpat      = win_q ? RPAT : LPAT;
  // Blink starts lit at count 0, so even counts are the "on" half of each pair.
  assign phase_on  = ((cnt_val & CW'(1)) == '0);

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    sl_d    = sl_q;
    sr_d    = sr_q;
    cnt_en  = 1'b0;
    cnt_clr = 1'b0;
    cnt_tc  = (state_q == HOLD) ? HOLD_TC : BLINK_TC;
    if (new_match) begin
      state_d = IDLE;
      sl_d    = '0;
      sr_d    = '0;
      cnt_clr = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (slowen256 && over) begin
            win_d = winright;
            if (winright) begin
              if (sr_q != RTW) sr_d = sr_q + SCORE_W'(1);
            end else begin
              if (sl_q != RTW) sl_d = sl_q + SCORE_W'(1);
            end
            cnt_clr = 1'b1;
            state_d = ROUND_ENTRY;
          end
        end
        BLINK: begin
          if (slowen256) begin
            if (cnt_hit) begin
              cnt_clr = 1'b1;
              state_d = HOLD;
            end else begin
              cnt_en = 1'b1;
            end
          end
        end
        HOLD: begin
          if (slowen256) begin
            if (cnt_hit) begin
              cnt_clr = 1'b1;
              state_d = (win_score == RTW) ? MATCH : IDLE;
            end else begin
              cnt_en = 1'b1;
            end
          end
        end
        MATCH:   state_d = MATCH;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      win_q   <= 1'b0;
      sl_q    <= '0;
      sr_q    <= '0;
      busy_q  <= 1'b0;
      match_q <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      sl_q    <= sl_d;
      sr_q    <= sr_d;
      busy_q  <= (state_d != IDLE);
      match_q <= (state_d == MATCH);
    end
  end

`ifdef VICT_SWEEP_EN
  logic [CW-1:0]    sweep_k;
  logic             sweep_hit, sweep_clr;
  logic [NLEDS-1:0] match_pat;

  // Offset from centre; restarts at 0 on MATCH entry and after touching the edge.
  assign sweep_clr = (state_q != MATCH) || (slowen256 && sweep_hit);

  vict_tick_cnt #(.W(CW)) u_sweep (
    .clk      (clk),
    .rst      (rst),
    .en_i     (slowen256),
    .clr_i    (sweep_clr),
    .tc_i     (CW'(C)),
    .cnt_o    (sweep_k),
    .tc_hit_o (sweep_hit)
  );

  assign match_pat = win_q ? (CTR >> sweep_k) : (CTR << sweep_k);
`else
  logic [NLEDS-1:0] match_pat;
  assign match_pat = wpat;
`endif

  always_comb begin
    vict_leds = CTR;
    case (state_q)
      IDLE:    vict_leds = CTR;
      BLINK:   vict_leds = phase_on ? wpat : '0;
      HOLD:    vict_leds = wpat;
      MATCH:   vict_leds = match_pat;
      default: vict_leds = CTR;
    endcase
  end

  assign busy       = busy_q;
  assign match_over = match_q;
  assign score_l    = sl_q;
  assign score_r    = sr_q;

endmodule
`default_nettype wire
